// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper datapath.
//   - default coordinate widths for the 16x16 board
//   - cover array encodings and the mine bit position in a board cell
//   - state encoding of the cascade-open engine (open_flood)
//   - apparent cell codes used by the top level when rendering the board
//   - neighbour direction offsets (0..7 = NW, N, NE, W, E, SW, S, SE)
package minesweeper_pkg;

  localparam int X_COORD_BITS = 4;
  localparam int Y_COORD_BITS = 4;

  // Board cell: bit 4 = mine, bits [3:0] = neighbour mine count.
  localparam int MINE_BIT = 4;

  // Cover cell: 00 hidden, 01 open, 1x flagged.
  localparam logic [1:0] COVER_HIDDEN = 2'b00;
  localparam logic [1:0] COVER_OPEN   = 2'b01;
  localparam logic [1:0] COVER_FLAG   = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    POP,
    NEIGH,
    DONE
  } flood_state_e;

  // What the player sees for a cell: counts 0..8 are shown as themselves.
  typedef enum logic [3:0] {
    CELL_N0, CELL_N1, CELL_N2, CELL_N3, CELL_N4,
    CELL_N5, CELL_N6, CELL_N7, CELL_N8,
    CELL_HIDDEN,
    CELL_FLAG,
    CELL_MINE,
    CELL_BOOM
  } cell_val_apparent_e;

  function automatic logic signed [1:0] dir_dx(input logic [2:0] dir);
    case (dir)
      3'd0, 3'd3, 3'd5: dir_dx = -2'sd1;
      3'd1, 3'd6:       dir_dx = 2'sd0;
      default:          dir_dx = 2'sd1;
    endcase
  endfunction

  function automatic logic signed [1:0] dir_dy(input logic [2:0] dir);
    case (dir)
      3'd0, 3'd1, 3'd2: dir_dy = -2'sd1;
      3'd3, 3'd4:       dir_dy = 2'sd0;
      default:          dir_dy = 2'sd1;
    endcase
  endfunction

endpackage

// File: rtl/coord_stack.sv
// LIFO of packed {y, x} coordinates for the flood walk.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (pointer only)
//   clr            synchronous empty (game abort)
//   push/push_data write a new entry on top (dropped when full)
//   pop            discard the top entry (ignored when empty)
//   top            combinational view of the top entry
//   empty/full     occupancy flags
// A simultaneous push and pop replaces the top entry.
module coord_stack #(
  parameter int W     = 8,
  parameter int depth = 256
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int PW = $clog2(depth + 1);

  logic [W-1:0]  mem_q [depth];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] top_idx, wr_idx;
  logic          do_push, do_pop;

  assign empty   = (ptr_q == '0);
  assign full    = (ptr_q == PW'(depth));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // ptr_q counts entries, so the top lives one below it.
  assign top_idx = AW'(ptr_q - PW'(1));
  assign wr_idx  = do_pop ? top_idx : AW'(ptr_q);
  assign top     = mem_q[top_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (do_push && !do_pop) begin
      ptr_d = ptr_q + PW'(1);
    end else if (do_pop && !do_push) begin
      ptr_d = ptr_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage carries no reset; only entries below the pointer are meaningful.
  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/open_flood.sv
// Cascade-open engine for the minesweeper board.
// A single open request uncovers the target cell; if that cell has no
// neighbouring mines the connected zero region is walked with a coordinate
// stack and every reachable hidden, unflagged, non-mine cell is uncovered.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   soft_clr              synchronous abort back to idle, stack emptied
//   req_open, req_x/y     one-cycle open request and its target
//   board_val, cover_val  board / cover cell at cur_x/cur_y (same cycle)
//   cur_x, cur_y          probe / open address, muxed onto the arrays while busy
//   cov_open              open strobe to the cover array
//   busy, done, hit_mine  status; hit_mine is meaningful with done
//   cells_opened          number of cov_open strobes in the last operation
//   overflow              sticky: a push was attempted with the stack full
module open_flood
  import minesweeper_pkg::*;
#(
  parameter int x_size       = 16,
  parameter int y_size       = 16,
  parameter int x_coord_bits = X_COORD_BITS,
  parameter int y_coord_bits = Y_COORD_BITS,
  parameter int stack_depth  = x_size * y_size
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                soft_clr,
  input  logic                                req_open,
  input  logic [x_coord_bits-1:0]             req_x,
  input  logic [y_coord_bits-1:0]             req_y,
  input  logic [4:0]                          board_val,
  input  logic [1:0]                          cover_val,
  output logic [x_coord_bits-1:0]             cur_x,
  output logic [y_coord_bits-1:0]             cur_y,
  output logic                                cov_open,
  output logic                                busy,
  output logic                                done,
  output logic                                hit_mine,
  output logic [x_coord_bits+y_coord_bits:0]  cells_opened,
  output logic                                overflow
);

  localparam int XB = x_coord_bits;
  localparam int YB = y_coord_bits;
  localparam int XE = XB + 1;
  localparam int YE = YB + 1;
  localparam int SW = XB + YB;
  localparam int CW = SW + 1;

  flood_state_e   state_q, state_d;
  logic [XB-1:0]  cx_q, cx_d;
  logic [YB-1:0]  cy_q, cy_d;
  logic [XB-1:0]  lastx_q;
  logic [YB-1:0]  lasty_q;
  logic [2:0]     dir_q, dir_d;
  logic           hit_q, hit_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;

  logic signed [XB:0] nx_s;
  logic signed [YB:0] ny_s;
  logic               nb_in_range;
  logic               push_req;

  logic          stk_push, stk_pop, stk_empty, stk_full;
  logic [SW-1:0] stk_wdata, stk_top;

  coord_stack #(
    .W     (SW),
    .depth (stack_depth)
  ) u_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (soft_clr),
    .push      (stk_push),
    .push_data (stk_wdata),
    .pop       (stk_pop),
    .top       (stk_top),
    .empty     (stk_empty),
    .full      (stk_full)
  );

  // Neighbour coordinate one bit wider than the board so that -1 shows up
  // as a negative value rather than wrapping onto the far edge.
  always_comb begin
    nx_s = $signed({1'b0, cx_q}) + XE'(dir_dx(dir_q));
    ny_s = $signed({1'b0, cy_q}) + YE'(dir_dy(dir_q));
    nb_in_range = !nx_s[XB] && (int'(nx_s) < x_size) &&
                  !ny_s[YB] && (int'(ny_s) < y_size);
  end

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    dir_d     = dir_q;
    hit_d     = hit_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    cur_x     = lastx_q;
    cur_y     = lasty_q;
    cov_open  = 1'b0;
    done      = 1'b0;
    push_req  = 1'b0;
    stk_pop   = 1'b0;
    stk_wdata = {cy_q, cx_q};

    case (state_q)
      IDLE: begin
        if (req_open) begin
          cx_d    = req_x;
          cy_d    = req_y;
          cnt_d   = '0;
          hit_d   = 1'b0;
          state_d = START;
        end
      end

      START: begin
        cur_x = cx_q;
        cur_y = cy_q;
        if (cover_val == COVER_HIDDEN) begin
          cov_open = 1'b1;
          if (board_val[MINE_BIT]) begin
            hit_d   = 1'b1;
            state_d = DONE;
          end else if (board_val[3:0] == 4'd0) begin
            push_req = 1'b1;
            state_d  = POP;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = DONE;
        end
      end

      POP: begin
        if (stk_empty) begin
          state_d = DONE;
        end else begin
          {cy_d, cx_d} = stk_top;
          stk_pop      = 1'b1;
          dir_d        = 3'd0;
          state_d      = NEIGH;
        end
      end

      NEIGH: begin
        cur_x     = nx_s[XB-1:0];
        cur_y     = ny_s[YB-1:0];
        stk_wdata = {ny_s[YB-1:0], nx_s[XB-1:0]};
        // Opening at push time marks the cell, so it can never be pushed again.
        if (nb_in_range && (cover_val == COVER_HIDDEN) && !board_val[MINE_BIT]) begin
          cov_open = 1'b1;
          if (board_val[3:0] == 4'd0) begin
            push_req = 1'b1;
          end
        end
        dir_d = dir_q + 3'd1;
        if (dir_q == 3'd7) begin
          state_d = POP;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (soft_clr) begin
      state_d  = IDLE;
      cov_open = 1'b0;
      done     = 1'b0;
      push_req = 1'b0;
      stk_pop  = 1'b0;
    end

    stk_push = push_req & ~stk_full;
    if (push_req && stk_full) begin
      ovf_d = 1'b1;
    end
    if (cov_open) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      lastx_q <= '0;
      lasty_q <= '0;
      dir_q   <= '0;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      lastx_q <= cur_x;
      lasty_q <= cur_y;
      dir_q   <= dir_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign hit_mine     = hit_q;
  assign cells_opened = cnt_q;
  assign overflow     = ovf_q;

endmodule
